// File: rtl/adc_sequencer.sv
// ADC conversion sequencer: trigger, wait for DVALID with timeout, capture, recover via ADC_RESET.
// Latency: ADC_TRIGGER one cycle after START; DATA_OUT/IRQ one cycle after DVALID; no input backpressure, START outside IDLE is dropped.
// Optional periodic auto-trigger is built in when ADC_SEQ_AUTO_TRIGGER_EN is defined.
module adc_sequencer #(
    parameter int WORD_SIZE      = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RESET_CYCLES   = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 ACK,
    input  logic                 AUTO_EN,
    input  logic [15:0]          PERIOD,
    input  logic [WORD_SIZE-1:0] ADC_DATA,
    input  logic                 ADC_DVALID,
    input  logic                 ADC_BUSY,
    output logic                 ADC_TRIGGER,
    output logic                 ADC_RESET,
    output logic [WORD_SIZE-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 IRQ,
    output logic                 SEQ_BUSY,
    output logic                 TIMEOUT_ERR,
    output logic                 OVERRUN
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_CAPTURE,
        S_RECOVER
    } state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    logic          start_req;

`ifdef ADC_SEQ_AUTO_TRIGGER_EN
    logic [15:0] pcnt;
    logic        auto_req;
    logic        unused_in;

    // Free-running period counter; a request that lands outside IDLE is simply lost.
    assign auto_req  = AUTO_EN && (PERIOD != 16'd0) && (pcnt >= PERIOD - 16'd1);
    assign start_req = START | auto_req;
    assign unused_in = ADC_BUSY;

    always_ff @(posedge CLK) begin
        if (RESET || !AUTO_EN || PERIOD == 16'd0) begin
            pcnt <= 16'd0;
        end else if (auto_req) begin
            pcnt <= 16'd0;
        end else begin
            pcnt <= pcnt + 16'd1;
        end
    end
`else
    logic unused_in;

    assign start_req = START;
    assign unused_in = ^{ADC_BUSY, AUTO_EN, PERIOD};
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            rcnt        <= '0;
            ADC_TRIGGER <= 1'b0;
            ADC_RESET   <= 1'b0;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            IRQ         <= 1'b0;
            SEQ_BUSY    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            OVERRUN     <= 1'b0;
        end else begin
            IRQ <= 1'b0;
            if (ACK) begin
                DATA_VALID <= 1'b0;
                OVERRUN    <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start_req && !ABORT) begin
                        state       <= S_TRIG;
                        ADC_TRIGGER <= 1'b1;
                        SEQ_BUSY    <= 1'b1;
                        TIMEOUT_ERR <= 1'b0;
                    end
                end
                S_TRIG: begin
                    ADC_TRIGGER <= 1'b0;
                    tcnt        <= '0;
                    if (ABORT) begin
                        state     <= S_RECOVER;
                        ADC_RESET <= 1'b1;
                        rcnt      <= '0;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ABORT) begin
                        state     <= S_RECOVER;
                        ADC_RESET <= 1'b1;
                        rcnt      <= '0;
                    end else if (ADC_DVALID) begin
                        // A capture on the last timeout cycle still counts as a capture.
                        state      <= S_CAPTURE;
                        DATA_OUT   <= ADC_DATA;
                        DATA_VALID <= 1'b1;
                        IRQ        <= 1'b1;
                        if (DATA_VALID && !ACK) begin
                            OVERRUN <= 1'b1;
                        end
                    end else if (tcnt == TMO_LAST) begin
                        state       <= S_RECOVER;
                        ADC_RESET   <= 1'b1;
                        rcnt        <= '0;
                        TIMEOUT_ERR <= 1'b1;
                        IRQ         <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    state    <= S_IDLE;
                    SEQ_BUSY <= 1'b0;
                end
                S_RECOVER: begin
                    if (rcnt == RST_LAST) begin
                        state     <= S_IDLE;
                        ADC_RESET <= 1'b0;
                        SEQ_BUSY  <= 1'b0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    ADC_TRIGGER <= 1'b0;
                    ADC_RESET   <= 1'b0;
                    SEQ_BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer against a transaction-level model of the sequencer.
module tb_adc_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       ACK = 1'b0;
    logic       AUTO_EN = 1'b0;
    logic [15:0] PERIOD = 16'd0;
    logic [7:0] ADC_DATA = 8'h00;
    logic       ADC_DVALID = 1'b0;
    logic       ADC_BUSY = 1'b0;
    logic       ADC_TRIGGER, ADC_RESET, DATA_VALID, IRQ, SEQ_BUSY, TIMEOUT_ERR, OVERRUN;
    logic [7:0] DATA_OUT;

    int errors = 0;
    int checks = 0;

    // Transaction-level expectations
    logic [7:0] m_data = 8'h00;
    bit         m_valid = 0;
    bit         m_ovr = 0;
    bit         m_terr = 0;

    // Pulse / occupancy monitors sampled mid-cycle
    int trig_cnt = 0, irq_cnt = 0, arst_cnt = 0, busy_cnt = 0;

    adc_sequencer #(.WORD_SIZE(8), .TIMEOUT_CYCLES(255), .RESET_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .ACK(ACK),
        .AUTO_EN(AUTO_EN), .PERIOD(PERIOD), .ADC_DATA(ADC_DATA),
        .ADC_DVALID(ADC_DVALID), .ADC_BUSY(ADC_BUSY), .ADC_TRIGGER(ADC_TRIGGER),
        .ADC_RESET(ADC_RESET), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
        .IRQ(IRQ), .SEQ_BUSY(SEQ_BUSY), .TIMEOUT_ERR(TIMEOUT_ERR), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ADC_TRIGGER) trig_cnt++;
        if (IRQ) irq_cnt++;
        if (ADC_RESET) arst_cnt++;
        if (SEQ_BUSY) busy_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!SEQ_BUSY) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    // One conversion: DVALID is presented after d WAIT cycles, optional ACK on the capture edge,
    // optional noise (DVALID outside WAIT, START during WAIT).
    task automatic run_conv(input int d, input logic [7:0] val, input bit ack_cap, input bit noise);
        if (noise) begin
            ADC_DVALID = 1'b1;
            ADC_DATA   = ~val;
        end
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        ADC_DVALID = 1'b0;
        if (noise && d >= 1) START = 1'b1;
        repeat (d) begin
            tick();
            START = 1'b0;
        end
        START      = 1'b0;
        ADC_DVALID = 1'b1;
        ADC_DATA   = val;
        ACK        = ack_cap;
        tick();
        ADC_DVALID = 1'b0;
        ACK        = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        checks++;
        if ({ADC_TRIGGER, ADC_RESET, DATA_OUT, DATA_VALID, IRQ, SEQ_BUSY, TIMEOUT_ERR, OVERRUN} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {ADC_TRIGGER, ADC_RESET, DATA_OUT, DATA_VALID, IRQ, SEQ_BUSY, TIMEOUT_ERR, OVERRUN});
        end
    endtask

    task automatic test_single();
        int t0, i0;
        t0 = trig_cnt; i0 = irq_cnt;
        START = 1'b1;
        tick();
        START = 1'b0;
        checks++;
        if (ADC_TRIGGER !== 1'b1) begin errors++; $display("FAIL trigger_rise: got %b want 1", ADC_TRIGGER); end
        tick();
        checks++;
        if (ADC_TRIGGER !== 1'b0 || SEQ_BUSY !== 1'b1) begin
            errors++; $display("FAIL trigger_fall: trig=%b busy=%b want 0/1", ADC_TRIGGER, SEQ_BUSY);
        end
        repeat (4) tick();
        ADC_DVALID = 1'b1; ADC_DATA = 8'hA5;
        tick();
        ADC_DVALID = 1'b0;
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL capture_irq: got %b want 1", IRQ); end
        tick();
        m_data = 8'hA5; m_valid = 1; m_ovr = 0;
        checks++;
        if (DATA_OUT !== m_data || DATA_VALID !== 1'b1 || IRQ !== 1'b0 || SEQ_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: data=%h dv=%b irq=%b busy=%b want %h/1/0/0",
                     DATA_OUT, DATA_VALID, IRQ, SEQ_BUSY, m_data);
        end
        checks++;
        if (trig_cnt - t0 !== 1 || irq_cnt - i0 !== 1) begin
            errors++; $display("FAIL single_pulses: trig=%0d irq=%0d want 1/1", trig_cnt - t0, irq_cnt - i0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int d, mode, t0, i0, b0;
            bit noise;
            logic [7:0] val;
            d = $urandom_range(0, 20);
            mode = $urandom_range(0, 2);
            noise = 1'($urandom_range(0, 1));
            val = 8'($urandom);
            if (mode == 1) begin
                ACK = 1'b1; tick(); ACK = 1'b0;
                m_valid = 0; m_ovr = 0;
            end
            t0 = trig_cnt; i0 = irq_cnt; b0 = busy_cnt;
            run_conv(d, val, mode == 2, noise);
            if (mode == 2) m_ovr = 0;
            else if (m_valid) m_ovr = 1;
            m_valid = 1; m_data = val; m_terr = 0;
            checks++;
            if (DATA_OUT !== m_data || DATA_VALID !== m_valid || OVERRUN !== m_ovr || TIMEOUT_ERR !== m_terr) begin
                errors++;
                $display("FAIL rand_state[%0d]: data=%h dv=%b ov=%b te=%b want %h/%b/%b/%b", n,
                         DATA_OUT, DATA_VALID, OVERRUN, TIMEOUT_ERR, m_data, m_valid, m_ovr, m_terr);
            end
            checks++;
            if (trig_cnt - t0 !== 1 || irq_cnt - i0 !== 1 || busy_cnt - b0 !== d + 3) begin
                errors++;
                $display("FAIL rand_timing[%0d]: trig=%0d irq=%0d busy=%0d want 1/1/%0d", n,
                         trig_cnt - t0, irq_cnt - i0, busy_cnt - b0, d + 3);
            end
        end
    endtask

    task automatic test_overrun();
        ACK = 1'b1; tick(); ACK = 1'b0;
        run_conv($urandom_range(0, 6), 8'h11, 1'b0, 1'b0);
        run_conv($urandom_range(0, 6), 8'h22, 1'b0, 1'b0);
        checks++;
        if (OVERRUN !== 1'b1 || DATA_OUT !== 8'h22 || DATA_VALID !== 1'b1) begin
            errors++; $display("FAIL overrun_set: ov=%b data=%h dv=%b want 1/22/1", OVERRUN, DATA_OUT, DATA_VALID);
        end
        ACK = 1'b1; tick(); ACK = 1'b0;
        m_data = 8'h22; m_valid = 0; m_ovr = 0;
        checks++;
        if (OVERRUN !== 1'b0 || DATA_VALID !== 1'b0) begin
            errors++; $display("FAIL overrun_ack: ov=%b dv=%b want 0/0", OVERRUN, DATA_VALID);
        end
    endtask

    task automatic test_abort();
        int t0, i0, a0, b0, exp_busy;
        bit ok;
        t0 = trig_cnt;
        START = 1'b1; ABORT = 1'b1; tick();
        START = 1'b0; ABORT = 1'b0; tick();
        checks++;
        if (SEQ_BUSY !== 1'b0 || trig_cnt - t0 !== 0) begin
            errors++; $display("FAIL abort_beats_start: busy=%b trig=%0d want 0/0", SEQ_BUSY, trig_cnt - t0);
        end
        for (int n = 0; n < 4; n++) begin
            int k;
            k = (n == 0) ? -1 : $urandom_range(0, 30);
            i0 = irq_cnt; a0 = arst_cnt; b0 = busy_cnt;
            START = 1'b1; tick(); START = 1'b0;
            if (k >= 0) begin
                tick();
                repeat (k) tick();
            end
            ABORT = 1'b1; tick(); ABORT = 1'b0;
            wait_idle(ok);
            exp_busy = (k < 0) ? 5 : k + 6;
            checks++;
            if (!ok || busy_cnt - b0 !== exp_busy || arst_cnt - a0 !== 4 || irq_cnt - i0 !== 0) begin
                errors++;
                $display("FAIL abort_timing[%0d]: ok=%b busy=%0d arst=%0d irq=%0d want 1/%0d/4/0", n,
                         ok, busy_cnt - b0, arst_cnt - a0, irq_cnt - i0, exp_busy);
            end
            m_terr = 0;
            checks++;
            if (TIMEOUT_ERR !== 1'b0 || DATA_OUT !== m_data || DATA_VALID !== m_valid) begin
                errors++;
                $display("FAIL abort_state[%0d]: te=%b data=%h dv=%b want 0/%h/%b", n,
                         TIMEOUT_ERR, DATA_OUT, DATA_VALID, m_data, m_valid);
            end
        end
    endtask

    task automatic test_timeout();
        int i0, a0, b0;
        bit ok;
        i0 = irq_cnt; a0 = arst_cnt; b0 = busy_cnt;
        START = 1'b1; tick(); START = 1'b0;
        tick();
        wait_idle(ok);
        m_terr = 1;
        checks++;
        if (!ok || busy_cnt - b0 !== 1 + 256 + 4 || irq_cnt - i0 !== 1 || arst_cnt - a0 !== 4) begin
            errors++;
            $display("FAIL timeout_timing: ok=%b busy=%0d irq=%0d arst=%0d want 1/261/1/4",
                     ok, busy_cnt - b0, irq_cnt - i0, arst_cnt - a0);
        end
        checks++;
        if (TIMEOUT_ERR !== 1'b1 || DATA_OUT !== m_data || DATA_VALID !== m_valid) begin
            errors++;
            $display("FAIL timeout_state: te=%b data=%h dv=%b want 1/%h/%b", TIMEOUT_ERR, DATA_OUT, DATA_VALID, m_data, m_valid);
        end
    endtask

    task automatic test_boundary();
        int i0, a0, b0;
        logic [7:0] val;
        val = 8'($urandom);
        i0 = irq_cnt; a0 = arst_cnt; b0 = busy_cnt;
        run_conv(255, val, 1'b0, 1'b0);
        m_ovr = m_valid ? 1'b1 : m_ovr;
        m_valid = 1; m_data = val; m_terr = 0;
        checks++;
        if (TIMEOUT_ERR !== 1'b0 || DATA_OUT !== m_data || DATA_VALID !== 1'b1 || OVERRUN !== m_ovr) begin
            errors++;
            $display("FAIL last_cycle_capture: te=%b data=%h dv=%b ov=%b want 0/%h/1/%b",
                     TIMEOUT_ERR, DATA_OUT, DATA_VALID, OVERRUN, m_data, m_ovr);
        end
        checks++;
        if (busy_cnt - b0 !== 258 || irq_cnt - i0 !== 1 || arst_cnt - a0 !== 0) begin
            errors++;
            $display("FAIL last_cycle_timing: busy=%0d irq=%0d arst=%0d want 258/1/0",
                     busy_cnt - b0, irq_cnt - i0, arst_cnt - a0);
        end
    endtask

    task automatic test_reset_mid();
        int i0;
        START = 1'b1; tick(); START = 1'b0;
        tick();
        repeat (3) tick();
        RESET = 1'b1; tick(); RESET = 1'b0;
        m_data = 8'h00; m_valid = 0; m_ovr = 0; m_terr = 0;
        checks++;
        if ({ADC_TRIGGER, ADC_RESET, DATA_OUT, DATA_VALID, IRQ, SEQ_BUSY, TIMEOUT_ERR, OVERRUN} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: got %b want all zero",
                     {ADC_TRIGGER, ADC_RESET, DATA_OUT, DATA_VALID, IRQ, SEQ_BUSY, TIMEOUT_ERR, OVERRUN});
        end
        i0 = irq_cnt;
        ADC_DVALID = 1'b1; ADC_DATA = 8'h5A; tick();
        ADC_DVALID = 1'b0; tick();
        checks++;
        if (DATA_OUT !== 8'h00 || DATA_VALID !== 1'b0 || irq_cnt - i0 !== 0) begin
            errors++;
            $display("FAIL late_dvalid: data=%h dv=%b irq=%0d want 00/0/0", DATA_OUT, DATA_VALID, irq_cnt - i0);
        end
        START = 1'b1; tick(); START = 1'b0;
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        tick();
        checks++;
        if (ADC_RESET !== 1'b1) begin errors++; $display("FAIL recover_pulse: got %b want 1", ADC_RESET); end
        RESET = 1'b1; tick(); RESET = 1'b0;
        checks++;
        if (ADC_RESET !== 1'b0 || SEQ_BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_in_recover: arst=%b busy=%b want 0/0", ADC_RESET, SEQ_BUSY);
        end
    endtask

    task automatic test_auto();
        int times[$];
        int t0;
        bit ok;
        t0 = trig_cnt;
        AUTO_EN = 1'b1;
`ifdef ADC_SEQ_AUTO_TRIGGER_EN
        PERIOD = 16'd100;
`else
        PERIOD = 16'($urandom_range(1, 50));
`endif
        ADC_DVALID = 1'b1; ADC_DATA = 8'h3C;
        for (int c = 0; c < 350; c++) begin
            tick();
            if (ADC_TRIGGER) times.push_back(c);
        end
        AUTO_EN = 1'b0;
        wait_idle(ok);
        ADC_DVALID = 1'b0;
        ACK = 1'b1; tick(); ACK = 1'b0;
        m_valid = 0; m_ovr = 0;
`ifdef ADC_SEQ_AUTO_TRIGGER_EN
        m_data = 8'h3C;
        checks++;
        if (!ok || times.size() < 3) begin
            errors++; $display("FAIL auto_count: ok=%b triggers=%0d want >=3", ok, times.size());
        end
        for (int i = 1; i < times.size(); i++) begin
            checks++;
            if (times[i] - times[i-1] !== 100) begin
                errors++; $display("FAIL auto_spacing[%0d]: got %0d want 100", i, times[i] - times[i-1]);
            end
        end
`else
        checks++;
        if (!ok || trig_cnt - t0 !== 0) begin
            errors++; $display("FAIL auto_disabled: ok=%b triggers=%0d want 0", ok, trig_cnt - t0);
        end
`endif
        checks++;
        if (DATA_OUT !== m_data || DATA_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL auto_state: data=%h dv=%b ov=%b want %h/0/0", DATA_OUT, DATA_VALID, OVERRUN, m_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_overrun();
        test_abort();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_auto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
